// File: rtl/hpdcache_mem_read_arbiter.sv
// Two-requester read arbiter toward memory: round-robin request stage with
// per-requester outstanding limits, and a combinational response demux.
module hpdcache_mem_read_arbiter #(
   parameter int unsigned ADDR_W    = 56,
   parameter int unsigned ID_W      = 6,
   parameter int unsigned DATA_W    = 512,
   parameter int unsigned MAX_OUTST = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [1:0]            req_valid_i,
   output logic [1:0]            req_ready_o,
   input  logic [2*ADDR_W-1:0]   req_addr_i,
   input  logic [2*ID_W-1:0]     req_id_i,
   output logic                  mem_req_valid_o,
   input  logic                  mem_req_ready_i,
   output logic [ADDR_W-1:0]     mem_req_addr_o,
   output logic [ID_W:0]         mem_req_id_o,
   input  logic                  mem_rsp_valid_i,
   output logic                  mem_rsp_ready_o,
   input  logic [ID_W:0]         mem_rsp_id_i,
   input  logic [DATA_W-1:0]     mem_rsp_data_i,
   input  logic                  mem_rsp_last_i,
   output logic [1:0]            rsp_valid_o,
   input  logic [1:0]            rsp_ready_i,
   output logic [ID_W-1:0]       rsp_id_o,
   output logic [DATA_W-1:0]     rsp_data_o,
   output logic                  rsp_last_o,
   output logic                  idle_o
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ID_W:0]     id_q, id_d;
   logic              prio_q, prio_d;
   logic [CNT_W-1:0]  cnt_q [2];
   logic [CNT_W-1:0]  cnt_d [2];

   logic [1:0] eligible;
   logic       stage_free;
   logic       grant_valid;
   logic       grant_idx;
   logic       rsp_src;
   logic       rsp_hs;
   logic [1:0] dec_at_zero;

   // Grant is suppressed during reset so no handshake is ever reported then.
   always_comb begin
      stage_free  = !out_valid_q || mem_req_ready_i;
      eligible[0] = req_valid_i[0] && (cnt_q[0] < CNT_MAX);
      eligible[1] = req_valid_i[1] && (cnt_q[1] < CNT_MAX);
      grant_valid = stage_free && (|eligible) && !rst_i;
      grant_idx   = (&eligible) ? prio_q : eligible[1];
      req_ready_o = 2'b00;
      if (grant_valid) begin
         req_ready_o = grant_idx ? 2'b10 : 2'b01;
      end
   end

   always_comb begin
      rsp_src         = mem_rsp_id_i[ID_W];
      rsp_valid_o     = {mem_rsp_valid_i && rsp_src, mem_rsp_valid_i && !rsp_src};
      mem_rsp_ready_o = rsp_ready_i[rsp_src];
      rsp_hs          = mem_rsp_valid_i && mem_rsp_ready_o;
      rsp_id_o        = mem_rsp_id_i[ID_W-1:0];
      rsp_data_o      = mem_rsp_data_i;
      rsp_last_o      = mem_rsp_last_i;
   end

   // A new grant refills the stage in the same cycle the old entry drains.
   always_comb begin
      out_valid_d = out_valid_q;
      addr_d      = addr_q;
      id_d        = id_q;
      prio_d      = prio_q;
      if (grant_valid) begin
         out_valid_d = 1'b1;
         addr_d      = grant_idx ? req_addr_i[ADDR_W +: ADDR_W] : req_addr_i[0 +: ADDR_W];
         id_d        = {grant_idx, grant_idx ? req_id_i[ID_W +: ID_W] : req_id_i[0 +: ID_W]};
         prio_d      = !grant_idx;
      end else if (mem_req_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         logic inc;
         logic dec;
         inc            = grant_valid && (grant_idx == 1'(k));
         dec            = rsp_hs && mem_rsp_last_i && (rsp_src == 1'(k));
         cnt_d[k]       = cnt_q[k];
         dec_at_zero[k] = dec && !inc && (cnt_q[k] == CNT_ZERO);
         if (inc && !dec) begin
            cnt_d[k] = cnt_q[k] + CNT_ONE;
         end else if (dec && !inc && (cnt_q[k] != CNT_ZERO)) begin
            cnt_d[k] = cnt_q[k] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         prio_q      <= 1'b0;
         cnt_q[0]    <= CNT_ZERO;
         cnt_q[1]    <= CNT_ZERO;
      end else begin
         out_valid_q <= out_valid_d;
         prio_q      <= prio_d;
         cnt_q[0]    <= cnt_d[0];
         cnt_q[1]    <= cnt_d[1];
      end
   end

   always_ff @(posedge clk_i) begin
      addr_q <= addr_d;
      id_q   <= id_d;
   end

   assign mem_req_valid_o = out_valid_q && !rst_i;
   assign mem_req_addr_o  = addr_q;
   assign mem_req_id_o    = id_q;
   assign idle_o          = rst_i || (!out_valid_q && (cnt_q[0] == CNT_ZERO) && (cnt_q[1] == CNT_ZERO));

   // A last beat for a requester with nothing outstanding is a protocol error.
   assert property (@(posedge clk_i) disable iff (rst_i) dec_at_zero == 2'b00);

endmodule

// File: tb/tb_hpdcache_mem_read_arbiter.sv
// Directed bench for hpdcache_mem_read_arbiter with MAX_OUTST = 2 and
// hand-computed expectations for arbitration, stalls, limits and reset.
module tb_hpdcache_mem_read_arbiter;

   localparam int AW = 16;
   localparam int IW = 6;
   localparam int DW = 32;
   localparam int MO = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    reqValid = 2'b00;
   logic [1:0]    reqReady;
   logic [AW-1:0] addr0 = '0;
   logic [AW-1:0] addr1 = '0;
   logic [IW-1:0] id0 = '0;
   logic [IW-1:0] id1 = '0;
   logic          memReqValid;
   logic          memReqReady = 1'b0;
   logic [AW-1:0] memReqAddr;
   logic [IW:0]   memReqId;
   logic          memRspValid = 1'b0;
   logic          memRspReady;
   logic [IW:0]   memRspId = '0;
   logic [DW-1:0] memRspData = '0;
   logic          memRspLast = 1'b0;
   logic [1:0]    rspValid;
   logic [1:0]    rspReady = 2'b00;
   logic [IW-1:0] rspId;
   logic [DW-1:0] rspData;
   logic          rspLast;
   logic          idle;

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   hpdcache_mem_read_arbiter #(
      .ADDR_W(AW), .ID_W(IW), .DATA_W(DW), .MAX_OUTST(MO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .req_valid_i(reqValid),
      .req_ready_o(reqReady),
      .req_addr_i({addr1, addr0}),
      .req_id_i({id1, id0}),
      .mem_req_valid_o(memReqValid),
      .mem_req_ready_i(memReqReady),
      .mem_req_addr_o(memReqAddr),
      .mem_req_id_o(memReqId),
      .mem_rsp_valid_i(memRspValid),
      .mem_rsp_ready_o(memRspReady),
      .mem_rsp_id_i(memRspId),
      .mem_rsp_data_i(memRspData),
      .mem_rsp_last_i(memRspLast),
      .rsp_valid_o(rspValid),
      .rsp_ready_i(rspReady),
      .rsp_id_o(rspId),
      .rsp_data_o(rspData),
      .rsp_last_o(rspLast),
      .idle_o(idle)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] rv, input logic mr);
      reqValid    = rv;
      memReqReady = mr;
      #1;
   endtask

   task automatic applyResponse(input logic v, input logic [IW:0] id, input logic last,
                                input logic [1:0] rdy);
      memRspValid = v;
      memRspId    = id;
      memRspLast  = last;
      rspReady    = rdy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      // Reset window: outputs forced quiet even with requests pending.
      reqValid = 2'b11;
      tick();
      tick();
      checkOutput("rst_ready", 64'(reqReady), 64'h0);
      checkOutput("rst_mvalid", 64'(memReqValid), 64'h0);
      checkOutput("rst_idle", 64'(idle), 64'h1);

      // Alternating grants with both requesters valid and memory ready.
      addr0 = 16'h1000; addr1 = 16'h2000; id0 = 6'h05; id1 = 6'h09;
      rst = 1'b0;
      applyStimulus(2'b11, 1'b1);
      checkOutput("rr_c0_ready", 64'(reqReady), 64'h1);
      checkOutput("rr_c0_mvalid", 64'(memReqValid), 64'h0);
      tick();
      checkOutput("rr_c1_mvalid", 64'(memReqValid), 64'h1);
      checkOutput("rr_c1_addr", 64'(memReqAddr), 64'h1000);
      checkOutput("rr_c1_id", 64'(memReqId), 64'h05);
      checkOutput("rr_c1_ready", 64'(reqReady), 64'h2);
      tick();
      checkOutput("rr_c2_mvalid", 64'(memReqValid), 64'h1);
      checkOutput("rr_c2_addr", 64'(memReqAddr), 64'h2000);
      checkOutput("rr_c2_id", 64'(memReqId), 64'h49);
      checkOutput("rr_c2_ready", 64'(reqReady), 64'h1);
      tick();
      checkOutput("rr_c3_mvalid", 64'(memReqValid), 64'h1);
      checkOutput("rr_c3_id", 64'(memReqId), 64'h05);
      checkOutput("rr_c3_ready", 64'(reqReady), 64'h2);
      tick();
      checkOutput("rr_c4_mvalid", 64'(memReqValid), 64'h1);
      checkOutput("rr_c4_id", 64'(memReqId), 64'h49);
      checkOutput("rr_c4_full", 64'(reqReady), 64'h0);
      applyStimulus(2'b00, 1'b1);
      tick();
      checkOutput("rr_c5_mvalid", 64'(memReqValid), 64'h0);
      checkOutput("rr_c5_idle", 64'(idle), 64'h0);

      // Response demux with destination not ready, then ready.
      memRspData = 32'hDEADBEEF;
      applyResponse(1'b1, 7'h6A, 1'b1, 2'b01);
      checkOutput("rsp_valid", 64'(rspValid), 64'h2);
      checkOutput("rsp_id", 64'(rspId), 64'h2A);
      checkOutput("rsp_data", 64'(rspData), 64'hDEADBEEF);
      checkOutput("rsp_last", 64'(rspLast), 64'h1);
      checkOutput("rsp_ready_lo", 64'(memRspReady), 64'h0);
      tick();
      applyStimulus(2'b10, 1'b1);
      checkOutput("rsp_nohs_full", 64'(reqReady), 64'h0);
      applyStimulus(2'b00, 1'b1);
      applyResponse(1'b1, 7'h6A, 1'b1, 2'b11);
      checkOutput("rsp_ready_hi", 64'(memRspReady), 64'h1);
      tick();
      applyResponse(1'b1, 7'h00, 1'b1, 2'b01);
      checkOutput("rsp_valid0", 64'(rspValid), 64'h1);
      tick();
      tick();
      applyResponse(1'b1, 7'h40, 1'b0, 2'b10);
      checkOutput("drain_idle_a", 64'(idle), 64'h0);
      tick();
      checkOutput("drain_idle_b", 64'(idle), 64'h0);
      applyResponse(1'b1, 7'h40, 1'b1, 2'b10);
      tick();
      applyResponse(1'b0, 7'h00, 1'b0, 2'b00);
      checkOutput("drain_idle_c", 64'(idle), 64'h1);

      // Stall: stage holds its contents while memory is not ready.
      addr0 = 16'hABCD; id0 = 6'h11;
      applyStimulus(2'b01, 1'b0);
      checkOutput("stall_grant", 64'(reqReady), 64'h1);
      tick();
      addr0 = 16'h5555; id0 = 6'h22;
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput($sformatf("stall_addr%0d", i), 64'(memReqAddr), 64'hABCD);
         checkOutput($sformatf("stall_id%0d", i), 64'(memReqId), 64'h11);
         checkOutput($sformatf("stall_ready%0d", i), 64'(reqReady), 64'h0);
         checkOutput($sformatf("stall_mvalid%0d", i), 64'(memReqValid), 64'h1);
         tick();
      end
      applyStimulus(2'b01, 1'b1);
      checkOutput("stall_release", 64'(reqReady), 64'h1);
      tick();
      applyStimulus(2'b00, 1'b1);
      checkOutput("stall_next_addr", 64'(memReqAddr), 64'h5555);
      checkOutput("stall_next_id", 64'(memReqId), 64'h22);
      tick();
      checkOutput("stall_empty", 64'(memReqValid), 64'h0);
      applyResponse(1'b1, 7'h00, 1'b1, 2'b01);
      tick();
      tick();
      applyResponse(1'b0, 7'h00, 1'b0, 2'b00);
      checkOutput("stall_idle", 64'(idle), 64'h1);

      // Outstanding limit on requester 1, released by a last beat.
      addr1 = 16'h3000; id1 = 6'h01;
      applyStimulus(2'b10, 1'b1);
      checkOutput("lim_g1", 64'(reqReady), 64'h2);
      tick();
      id1 = 6'h02;
      #1;
      checkOutput("lim_g2", 64'(reqReady), 64'h2);
      tick();
      id1 = 6'h03;
      #1;
      checkOutput("lim_block", 64'(reqReady), 64'h0);
      checkOutput("lim_id2", 64'(memReqId), 64'h42);
      tick();
      checkOutput("lim_block2", 64'(reqReady), 64'h0);
      checkOutput("lim_mvalid", 64'(memReqValid), 64'h0);
      applyResponse(1'b1, 7'h40, 1'b1, 2'b10);
      checkOutput("lim_same_cycle", 64'(reqReady), 64'h0);
      tick();
      applyResponse(1'b0, 7'h00, 1'b0, 2'b00);
      checkOutput("lim_release", 64'(reqReady), 64'h2);
      tick();
      applyStimulus(2'b00, 1'b1);
      checkOutput("lim_id3", 64'(memReqId), 64'h43);

      // Simultaneous grant and last beat on requester 1 keeps its count.
      applyResponse(1'b1, 7'h40, 1'b1, 2'b10);
      tick();
      id1 = 6'h04;
      applyStimulus(2'b10, 1'b1);
      checkOutput("sim_grant", 64'(reqReady), 64'h2);
      tick();
      applyResponse(1'b0, 7'h00, 1'b0, 2'b00);
      id1 = 6'h05;
      #1;
      checkOutput("sim_cnt_one", 64'(reqReady), 64'h2);
      tick();
      checkOutput("sim_cnt_full", 64'(reqReady), 64'h0);
      checkOutput("sim_idle_a", 64'(idle), 64'h0);
      applyStimulus(2'b00, 1'b1);
      tick();
      checkOutput("sim_idle_b", 64'(idle), 64'h0);
      applyResponse(1'b1, 7'h40, 1'b1, 2'b11);
      tick();
      checkOutput("sim_idle_c", 64'(idle), 64'h0);
      tick();
      applyResponse(1'b0, 7'h00, 1'b0, 2'b00);
      checkOutput("sim_idle_d", 64'(idle), 64'h1);

      // Reset while the stage is full, counts non-zero and priority on 1.
      addr0 = 16'h7777; id0 = 6'h06;
      applyStimulus(2'b01, 1'b1);
      tick();
      tick();
      applyStimulus(2'b11, 1'b0);
      checkOutput("prerst_mvalid", 64'(memReqValid), 64'h1);
      checkOutput("prerst_ready", 64'(reqReady), 64'h0);
      rst = 1'b1;
      #1;
      checkOutput("inrst_ready", 64'(reqReady), 64'h0);
      checkOutput("inrst_mvalid", 64'(memReqValid), 64'h0);
      checkOutput("inrst_idle", 64'(idle), 64'h1);
      tick();
      rst = 1'b0;
      applyStimulus(2'b11, 1'b1);
      checkOutput("postrst_mvalid", 64'(memReqValid), 64'h0);
      checkOutput("postrst_idle", 64'(idle), 64'h1);
      checkOutput("postrst_ready", 64'(reqReady), 64'h1);
      tick();
      checkOutput("postrst_id", 64'(memReqId), 64'h06);
      checkOutput("postrst_next", 64'(reqReady), 64'h2);
      applyStimulus(2'b00, 1'b1);
      tick();
      tick();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/hpdcache_mem_read_arbiter.md
HPDCACHE_MEM_READ_ARBITER -- requirements
Module: hpdcache_mem_read_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_W, 56, memory address width.
- ID_W, 6, per-requester transaction ID width.
- DATA_W, 512, memory response data width.
- MAX_OUTST, 8, maximum outstanding reads per requester (>=1).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning), clock and reset first:
- clk_i, in, 1, single clock; all state on rising edge.
- rst_i, in, 1, synchronous active-high reset.
- req_valid_i, in, 2, per requester (0 = miss-read, 1 = uncached-read) request valid.
- req_ready_o, out, 2, per requester request accepted.
- req_addr_i, in, 2*ADDR_W, per requester address; slice k = bits [k*ADDR_W +: ADDR_W].
- req_id_i, in, 2*ID_W, per requester transaction ID.
- mem_req_valid_o, out, 1, memory read request valid.
- mem_req_ready_i, in, 1, memory accepts request.
- mem_req_addr_o, out, ADDR_W, forwarded address.
- mem_req_id_o, out, ID_W+1, {source index, requester ID}.
- mem_rsp_valid_i, in, 1, memory response valid.
- mem_rsp_ready_o, out, 1, response accepted.
- mem_rsp_id_i, in, ID_W+1, response ID; MSB selects destination.
- mem_rsp_data_i, in, DATA_W, response data.
- mem_rsp_last_i, in, 1, final beat of transaction.
- rsp_valid_o, out, 2, per requester response valid.
- rsp_ready_i, in, 2, per requester response ready.
- rsp_id_o, out, ID_W, mem_rsp_id_i with MSB stripped (shared).
- rsp_data_o, out, DATA_W, mem_rsp_data_i (shared).
- rsp_last_o, out, 1, mem_rsp_last_i (shared).
- idle_o, out, 1, no stored request and both outstanding counters zero.

Function
REQ-003 Request path SHALL have one output register stage: out_valid_q, addr_q, id_q drive mem_req_*_o.
REQ-004 Stage SHALL be free when !out_valid_q or (out_valid_q and mem_req_ready_i); it loads at most one request per cycle.
REQ-005 Requester k SHALL be eligible when req_valid_i[k] and outst_cnt[k] < MAX_OUTST.
REQ-006 Round-robin: prio_q SHALL name the favoured requester; if both eligible, grant prio_q; if one eligible, grant it.
REQ-007 req_ready_o[k] SHALL be 1 only for the granted requester and only when the stage is free; never both bits set.
REQ-008 On grant k, the stage SHALL load {k, req_id_i[k]} and req_addr_i[k] next cycle, and prio_q SHALL become 1-k.
REQ-009 Without a grant, prio_q SHALL hold.
REQ-010 out_valid_q SHALL clear on mem_req_ready_i with no grant; with a grant in the same cycle it stays 1 (back-to-back, no bubble).
REQ-011 While out_valid_q and !mem_req_ready_i, mem_req_addr_o and mem_req_id_o SHALL stay stable.
REQ-012 outst_cnt[k] (width clog2(MAX_OUTST+1)) SHALL increment on grant k.
REQ-013 outst_cnt[k] SHALL decrement on a response handshake with mem_rsp_id_i MSB = k and mem_rsp_last_i = 1.
REQ-014 Simultaneous increment and decrement on the same counter SHALL leave it unchanged.
REQ-015 The counter SHALL never exceed MAX_OUTST or wrap below 0; a decrement at 0 is a protocol error flagged by a simulation assertion, and the counter holds 0.
REQ-016 Response path SHALL be combinational, zero latency: rsp_valid_o[k] = mem_rsp_valid_i and (MSB == k); mem_rsp_ready_o = rsp_ready_i[MSB].
REQ-017 Request and response paths SHALL be independent; response backpressure SHALL not stall requests unless a counter is full.
REQ-018 Latency from req handshake to mem_req_valid_o SHALL be 1 cycle.

Reset
REQ-019 While rst_i = 1, at the clock edge the block SHALL set: out_valid_q = 0, prio_q = 0, both counters = 0.
REQ-020 During reset, mem_req_valid_o = 0, req_ready_o = 0, idle_o = 1; in-flight requests and counts are discarded.
REQ-021 The first cycle after rst_i falls SHALL arbitrate normally.

Verification
REQ-022 Both requesters valid continuously, mem_req_ready_i = 1 -> grants alternate 0,1,0,1; mem_req_valid_o stays 1 from cycle 2, no bubble.
REQ-023 Requester 0 issues, mem_req_ready_i = 0 for 5 cycles -> address/ID stable, req_ready_o = 0 throughout, then one handshake.
REQ-024 MAX_OUTST = 2, requester 1 issues 3 requests with no responses -> third blocked; response with ID MSB = 1 and last = 1 -> third granted next cycle.
REQ-025 Response ID = {1, 6'h2A}, rsp_ready_i = 2'b01 -> rsp_valid_o = 2'b10, rsp_id_o = 6'h2A, mem_rsp_ready_o = 0 until rsp_ready_i[1] = 1.
REQ-026 Grant and last-beat response on the same counter in one cycle -> count unchanged; idle_o = 1 only after the final response and an empty stage.
REQ-027 rst_i asserted with out_valid_q = 1 and counts = 3 -> next cycle mem_req_valid_o = 0, idle_o = 1, prio_q = 0.
